// File: rtl/wb_pkg.sv
// Shared write-back definitions: exception bit positions, ECODE/ESUBCODE values
// and which exceptions load BADV.
package wb_pkg;

  localparam int MAX_EXC = 8;

  typedef enum logic [2:0] {
    EXC_INT  = 3'd0,
    EXC_ADEF = 3'd1,
    EXC_TLBR = 3'd2,
    EXC_ALE  = 3'd3,
    EXC_SYS  = 3'd4,
    EXC_BRK  = 3'd5,
    EXC_INE  = 3'd6,
    EXC_ADEM = 3'd7
  } exc_idx_e;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  // One bit per exception index: ADEF, TLBR, ALE and ADEM report a faulting address
  localparam logic [MAX_EXC-1:0] BADV_SRC_MASK = 8'b1000_1110;

  function automatic logic [5:0] exc_ecode(input exc_idx_e idx);
    case (idx)
      EXC_INT:  return ECODE_INT;
      EXC_ADEF: return ECODE_ADE;
      EXC_TLBR: return ECODE_TLBR;
      EXC_ALE:  return ECODE_ALE;
      EXC_SYS:  return ECODE_SYS;
      EXC_BRK:  return ECODE_BRK;
      EXC_INE:  return ECODE_INE;
      EXC_ADEM: return ECODE_ADE;
      default:  return 6'h00;
    endcase
  endfunction

  function automatic logic [8:0] exc_esubcode(input exc_idx_e idx);
    return (idx == EXC_ADEM) ? ESUB_ADEM : ESUB_ADEF;
  endfunction

endpackage

// File: rtl/wb_stage_px_if.sv
// MEM->WB payload, CSR handshake and WB result/trace signals of the write-back stage.
interface wb_stage_px_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_EXC = 8,
  parameter int CNT_W   = 32
);
  logic               ms_to_ws_valid;
  logic               ws_allowin;
  logic [DATA_W-1:0]  ms_pc;
  logic               ms_rf_we;
  logic [REG_AW-1:0]  ms_rf_waddr;
  logic [DATA_W-1:0]  ms_rf_wdata;
  logic [NUM_EXC-1:0] ms_exc;
  logic               ms_ertn;
  logic [DATA_W-1:0]  ms_badv;
  logic               csr_busy;
  logic               ws_rf_we;
  logic [REG_AW-1:0]  ws_rf_waddr;
  logic [DATA_W-1:0]  ws_rf_wdata;
  logic               wb_ex;
  logic               ertn_flush;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [DATA_W-1:0]  wb_pc;
  logic [DATA_W-1:0]  wb_badv;
  logic               wb_badv_we;
  logic [CNT_W-1:0]   retire_cnt;
  logic [DATA_W-1:0]  debug_wb_pc;
  logic [3:0]         debug_wb_rf_we;
  logic [REG_AW-1:0]  debug_wb_rf_wnum;
  logic [DATA_W-1:0]  debug_wb_rf_wdata;

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_exc, ms_ertn, ms_badv, csr_busy,
    output ws_allowin, ws_rf_we, ws_rf_waddr, ws_rf_wdata, wb_ex, ertn_flush,
           wb_ecode, wb_esubcode, wb_pc, wb_badv, wb_badv_we, retire_cnt,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_exc, ms_ertn, ms_badv, csr_busy,
    input  ws_allowin, ws_rf_we, ws_rf_waddr, ws_rf_wdata, wb_ex, ertn_flush,
           wb_ecode, wb_esubcode, wb_pc, wb_badv, wb_badv_we, retire_cnt,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_exc_prio.sv
// Fixed-priority exception selector: lowest set flag wins and supplies ECODE/ESUBCODE.
module wb_exc_prio
  import wb_pkg::*;
#(
  parameter int NUM_EXC = 8
) (
  input  logic [NUM_EXC-1:0] i_exc,
  output exc_idx_e           o_idx,
  output logic [5:0]         o_ecode,
  output logic [8:0]         o_esubcode,
  output logic               o_any
);

  logic [NUM_EXC:0]   w_seen;
  logic [NUM_EXC-1:0] w_hot;
  logic [2:0]         w_idx;

  // w_seen[k] is set when any flag below index k is already active
  assign w_seen[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < NUM_EXC; gi++) begin : g_chain
      assign w_seen[gi+1] = w_seen[gi] | i_exc[gi];
      assign w_hot[gi]    = i_exc[gi] & ~w_seen[gi];
    end
  endgenerate

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_EXC; i++) begin
      if (w_hot[i]) w_idx = w_idx | 3'(i);
    end
  end

  assign o_idx      = exc_idx_e'(w_idx);
  assign o_any      = w_seen[NUM_EXC];
  assign o_ecode    = o_any ? exc_ecode(o_idx)    : 6'h00;
  assign o_esubcode = o_any ? exc_esubcode(o_idx) : 9'h000;

endmodule

// File: rtl/wb_stage_px.sv
// Write-back pipeline stage: holds one MEM payload, commits register writes,
// raises exception / ertn flush pulses and counts retired instructions.
module wb_stage_px
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_EXC = 8,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         resetn,
  wb_stage_px_if.slave bus
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_pc;
  logic               r_rf_we;
  logic [REG_AW-1:0]  r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;
  logic [NUM_EXC-1:0] r_exc;
  logic               r_ertn;
  logic [DATA_W-1:0]  r_badv;
  logic [CNT_W-1:0]   r_retire_cnt;

  logic       w_ready_go;
  logic       w_allowin;
  logic       w_commit;
  logic       w_wb_ex;
  logic       w_ertn_flush;
  logic       w_flush;
  logic       w_rf_we;
  logic       w_badv_we;
  logic       w_exc_any;
  exc_idx_e   w_exc_idx;
  logic [5:0] w_ecode;
  logic [8:0] w_esubcode;

  wb_exc_prio #(.NUM_EXC(NUM_EXC)) u_prio (
    .i_exc      (r_exc),
    .o_idx      (w_exc_idx),
    .o_ecode    (w_ecode),
    .o_esubcode (w_esubcode),
    .o_any      (w_exc_any)
  );

  assign w_ready_go   = ~bus.csr_busy;
  assign w_allowin    = ~r_valid | w_ready_go;
  assign w_commit     = r_valid & w_ready_go;
  assign w_wb_ex      = w_commit & w_exc_any;
  assign w_ertn_flush = w_commit & r_ertn & ~w_exc_any;
  assign w_flush      = w_wb_ex | w_ertn_flush;
  assign w_rf_we      = w_commit & r_rf_we & ~w_wb_ex;
  assign w_badv_we    = w_wb_ex & BADV_SRC_MASK[3'(w_exc_idx)];

  // A flush can only happen on a commit, so allowin is 1 and the offered payload is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_exc        <= '0;
      r_ertn       <= 1'b0;
      r_badv       <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_flush) begin
        r_valid <= 1'b0;
      end else if (w_allowin) begin
        r_valid <= bus.ms_to_ws_valid;
        if (bus.ms_to_ws_valid) begin
          r_pc       <= bus.ms_pc;
          r_rf_we    <= bus.ms_rf_we;
          r_rf_waddr <= bus.ms_rf_waddr;
          r_rf_wdata <= bus.ms_rf_wdata;
          r_exc      <= bus.ms_exc;
          r_ertn     <= bus.ms_ertn;
          r_badv     <= bus.ms_badv;
        end
      end
      if (w_commit & ~w_wb_ex) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ws_allowin        = w_allowin;
  assign bus.ws_rf_we          = w_rf_we;
  assign bus.ws_rf_waddr       = r_rf_waddr;
  assign bus.ws_rf_wdata       = r_rf_wdata;
  assign bus.wb_ex             = w_wb_ex;
  assign bus.ertn_flush        = w_ertn_flush;
  assign bus.wb_ecode          = w_ecode;
  assign bus.wb_esubcode       = w_esubcode;
  assign bus.wb_pc             = r_pc;
  // Instruction-fetch faults report the PC itself as the bad address
  assign bus.wb_badv           = (w_exc_idx == EXC_ADEF) ? r_pc : r_badv;
  assign bus.wb_badv_we        = w_badv_we;
  assign bus.retire_cnt        = r_retire_cnt;
  assign bus.debug_wb_pc       = r_pc;
  assign bus.debug_wb_rf_we    = {4{w_rf_we}};
  assign bus.debug_wb_rf_wnum  = r_rf_waddr;
  assign bus.debug_wb_rf_wdata = r_rf_wdata;

endmodule

// File: doc/wb_stage_px.md
WB_STAGE_PX -- requirements
Module: wb_stage_px

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning PC, data and badv width.
REQ-002 The module SHALL have parameter REG_AW, default 5, meaning register-file address width.
REQ-003 The module SHALL have parameter NUM_EXC, default 8 (legal 1..8), meaning the number of exception flag bits.
REQ-004 The module SHALL have parameter CNT_W, default 32, meaning retire-counter width.
REQ-005 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  single clock, rising edge;
 resetn  in  1  reset, asynchronous, active-low;
 ms_to_ws_valid  in  1  MEM payload valid;
 ws_allowin  out  1  WB accepts payload;
 ms_pc  in  DATA_W  instruction PC;
 ms_rf_we / ms_rf_waddr / ms_rf_wdata  in  1 / REG_AW / DATA_W  register write request;
 ms_exc  in  NUM_EXC  exception flags, bit 0 highest priority;
 ms_ertn  in  1  ertn instruction;
 ms_badv  in  DATA_W  faulting data address;
 csr_busy  in  1  CSR unit not ready, stalls WB;
 ws_rf_we / ws_rf_waddr / ws_rf_wdata  out  1 / REG_AW / DATA_W  register-file write port;
 wb_ex  out  1  exception commit pulse;
 ertn_flush  out  1  ertn commit pulse;
 wb_ecode / wb_esubcode  out  6 / 9  exception code and subcode;
 wb_pc  out  DATA_W  exception return PC;
 wb_badv  out  DATA_W  bad virtual address;
 wb_badv_we  out  1  BADV update enable;
 retire_cnt  out  CNT_W  retired-instruction count;
 debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  DATA_W / 4 / REG_AW / DATA_W  trace port.

Function
REQ-006 ws_ready_go SHALL be ~csr_busy, and ws_allowin SHALL be ~ws_valid | ws_ready_go.
REQ-007 The payload SHALL be captured on a rising edge with ms_to_ws_valid & ws_allowin & ~flush, where flush = wb_ex | ertn_flush.
REQ-008 ws_valid SHALL be cleared on the edge after flush; a payload offered in the flush cycle SHALL be dropped.
REQ-009 Otherwise, when ws_allowin=1, ws_valid SHALL load ms_to_ws_valid; when ws_allowin=0, all WB state SHALL hold.
REQ-010 commit SHALL be ws_valid & ws_ready_go; wb_ex SHALL be commit & |exc, and ertn_flush SHALL be commit & ertn & ~|exc.
REQ-011 Both flush outputs SHALL be high for exactly one cycle per instruction.
REQ-012 wb_ecode/wb_esubcode SHALL come from the lowest-index set exc bit using this table:
 bit0 INT 0x00/0; bit1 ADEF 0x08/0; bit2 TLBR 0x3F/0; bit3 ALE 0x09/0;
 bit4 SYS 0x0B/0; bit5 BRK 0x0C/0; bit6 INE 0x0D/0; bit7 ADEM 0x08/1.
 Both outputs SHALL be 0 when no bit is set.
REQ-013 wb_badv_we SHALL be wb_ex & winner in {ADEF, TLBR, ALE, ADEM}; wb_badv SHALL be pc for ADEF, else the captured badv.
REQ-014 wb_pc and debug_wb_pc SHALL equal the captured pc.
REQ-015 ws_rf_we SHALL be commit & rf_we & ~wb_ex, and debug_wb_rf_we SHALL be {4{ws_rf_we}}; address and data SHALL be passed through unchanged.
REQ-016 retire_cnt SHALL increment by 1 on every commit without wb_ex (ertn counts) and SHALL wrap from all-ones to 0.
REQ-017 Exception bits at index >= NUM_EXC SHALL be treated as absent; the encoder SHALL be generated from NUM_EXC.

Reset
REQ-018 While resetn=0, asynchronously, ws_valid, the payload registers and retire_cnt SHALL be 0, so every output SHALL read 0 except ws_allowin, which SHALL read 1.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction with no flush pulse.

Structure
REQ-020 The ECODE/ESUBCODE constants, the bit-index enumeration and the badv-source mask SHALL live in the shared package wb_pkg.
REQ-021 Priority selection SHALL be one sub-module, wb_exc_prio (NUM_EXC flags -> winner index, ecode, esubcode, any).

Verification
REQ-022 Bench case: ld commits with rf_we=1, waddr=5, wdata=0x1234, no exc -> ws_rf_we=1 for one cycle, retire_cnt 0->1.
REQ-023 Bench case: exc=0x12 (ADEF+SYS), pc=0x1C000010 -> wb_ex one cycle, ecode 0x08, badv 0x1C000010, badv_we=1, ws_rf_we=0, retire_cnt unchanged.
REQ-024 Bench case: ertn with csr_busy=1 for 3 cycles -> ws_allowin=0, no pulse for 3 cycles; then ertn_flush for one cycle, and the next-cycle payload is dropped.
REQ-025 Bench case: back-to-back valid payloads with ms_to_ws_valid=1 each cycle -> one retire per cycle, no bubbles.
REQ-026 Bench case: CNT_W=4 with 17 commits -> retire_cnt=1.
REQ-027 Bench case: resetn low during a stall -> all outputs 0 and ws_allowin=1 immediately, and after release nothing commits until a new valid payload.
